// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester arbiter (instruction fetch, data) in front of a
// shared single-port memory with a fixed number of wait cycles per access.
// Each access runs IDLE -> ACCESS (WAIT_CYCLES+1 cycles) -> RESP (one cycle).
// Optional build macro ARB_ROUND_ROBIN_EN: alternate the winner on a tie.
// Without it, the data port always wins a tie.
module mem_arbiter #(
  parameter int WAIT_CYCLES = 1,
  parameter int AW          = 32,
  parameter int DW          = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t        state;
  logic          owner_d;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [3:0]    cnt;
  logic [DW-1:0] if_rdata_q;
  logic [DW-1:0] d_rdata_q;
  logic          pick_d;
  logic          in_access;

`ifdef ARB_ROUND_ROBIN_EN
  // last_d = 1 when the previous grant went to data; reset value prefers data.
  logic          last_d;

  // Track the most recent winner so a tie goes to the other requester.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_d <= 1'b0;
    end else if (if_gnt || d_gnt) begin
      last_d <= d_gnt;
    end
  end
`endif

  // Tie resolution and combinational grant in IDLE; all gated off in reset.
  always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
    pick_d = d_req && (!if_req || !last_d);
`else
    pick_d = d_req;
`endif
    d_gnt  = (state == IDLE) && !reset && pick_d;
    if_gnt = (state == IDLE) && !reset && if_req && !pick_d;
  end

  // Transaction FSM: latch the winning command, count wait cycles, respond.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      owner_d    <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (if_gnt || d_gnt) begin
            owner_d <= d_gnt;
            addr_q  <= d_gnt ? d_addr : if_addr;
            we_q    <= d_gnt && d_we;
            wdata_q <= d_gnt ? d_wdata : '0;
            cnt     <= WAIT_INIT;
            state   <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt == 4'd0) begin
            // Memory read data is only valid in the last access cycle.
            if (!we_q) begin
              if (owner_d) d_rdata_q  <= mem_rdata;
              else         if_rdata_q <= mem_rdata;
            end
            state <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Output decode from registered state; everything reads 0 while reset is high.
  always_comb begin
    in_access = (state == ACCESS) && !reset;
    mem_en    = in_access;
    mem_we    = in_access && we_q;
    mem_addr  = in_access ? addr_q  : '0;
    mem_wdata = in_access ? wdata_q : '0;
    if_rvalid = (state == RESP) && !reset && !owner_d;
    d_rvalid  = (state == RESP) && !reset && owner_d;
    if_rdata  = reset ? '0 : if_rdata_q;
    d_rdata   = reset ? '0 : d_rdata_q;
  end

endmodule
